ram_burst_master: RTL and testbench
===================================

Name: ram_burst_master

Overview:
- Initiator-side controller for the team's single-port asynchronous-read, level-write RAM (cs/wr/addr/data_in/data_out).
- Accepts burst commands on a valid/ready interface and streams write data in or read data out with handshakes.
- Generates safe RAM strobes: address and data are stable before and after every write-enable pulse.
- Sits between a bus/DMA client and the RAM instance.

Parameters:
ADDR_W, 10, RAM address width; addresses wrap modulo 2^ADDR_W
DATA_W, 8, RAM word width
LEN_W, 10, burst length field width; cmd_len = beats-1

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when valid&ready
cmd_wr  input  1  1=write burst, 0=read burst
cmd_addr  input  ADDR_W  burst start address
cmd_len  input  LEN_W  beats minus one
wdata_valid  input  1  write data available
wdata_ready  output  1  write data accepted when valid&ready
wdata  input  DATA_W  write data
rdata_valid  output  1  read data available
rdata_ready  input  1  read data consumed when valid&ready
rdata  output  DATA_W  read data
busy  output  1  burst in progress (state != IDLE)
done  output  1  one-cycle pulse at burst end
ram_cs  output  1  RAM chip select
ram_wr  output  1  RAM write enable (level)
ram_addr  output  ADDR_W  RAM address
ram_wdata  output  DATA_W  RAM data_in
ram_rdata  input  DATA_W  RAM data_out (combinational from ram_addr)
verify_err  output  1  sticky readback mismatch (see Optional Feature)
verify_addr  output  ADDR_W  address of first mismatch

Behaviour:
- Reset: asynchronous on rst_n low. State=IDLE. All outputs 0 except cmd_ready=1. ram_wr drops immediately. Any in-flight burst is abandoned; no done pulse.
- All outputs are registered. cmd_ready, wdata_ready and busy are decoded from the registered state.
- Beat counter: LEN_W bits. The burst ends on the beat where count==len. cmd_len=0 means 1 beat; the maximum is 2^LEN_W beats.
- Address: increments per beat, wrapping from 2^ADDR_W-1 to 0.
- IDLE: cmd_ready=1, ram_cs=0. On cmd_valid, latch addr/len/dir and clear count. Go to WWAIT if cmd_wr=1, otherwise RADDR.
- WWAIT: wdata_ready=1, ram_cs=0, ram_wr=0. On wdata_valid, latch wdata into ram_wdata and go to WSETUP.
- WSETUP: ram_cs=1, ram_wr=0, ram_addr/ram_wdata stable. Go to WSTROBE.
- WSTROBE: ram_wr=1 for exactly one cycle. Go to WHOLD.
- WHOLD: ram_cs=1, ram_wr=0, ram_addr/ram_wdata unchanged. Last beat: go to DONE. Otherwise addr++, count++, go to WWAIT.
- Write beat cost is 4 cycles minimum. ram_addr never changes in a cycle adjacent to ram_wr=1.
- RADDR: ram_cs=1, ram_wr=0, ram_addr driven. At the clock edge, capture ram_rdata into rdata and set rdata_valid=1. Go to RVALID.
- RVALID: ram_cs=0. rdata and rdata_valid hold until rdata_ready. On handshake, rdata_valid=0. Last beat: go to DONE. Otherwise addr++, count++, go to RADDR.
- Read beat cost is 2 cycles minimum. rdata_ready while rdata_valid=0 is ignored.
- DONE: done=1 for one cycle, busy=1, cmd_ready=0. Go to IDLE.
- cmd_valid outside IDLE is not accepted; the requester must hold it. wdata_valid outside WWAIT is ignored.
- ram_wr is never 1 while ram_cs=0.

Optional Feature:
- Macro: RAM_BURST_MASTER_VERIFY_EN.
- Defined: WHOLD goes to WCHK instead of advancing. In WCHK: ram_cs=1, ram_wr=0, same address. Compare ram_rdata with ram_wdata. On mismatch with verify_err=0, set verify_err=1 and capture verify_addr. WCHK then advances or finishes exactly as WHOLD does without the feature. Write beat is 5 cycles. verify_err/verify_addr clear on the next command acceptance.
- Undefined: no WCHK state; verify_err and verify_addr tied to 0.

Test Plan:
- Reset mid-write: assert rst_n=0 during WSTROBE of a write at 0x010. Require ram_wr=0 asynchronously, state IDLE, cmd_ready=1, busy=0, done=0, no further RAM activity.
- Single write then read: write cmd addr=0x005 len=0 with wdata=0xA5, then read cmd addr=0x005 len=0. Require exactly one ram_wr pulse at addr 0x005 with data 0xA5, rdata=0xA5 with rdata_valid, and done once per burst.
- Wrap burst: write addr=0x3FE len=3 with data 0x11,0x22,0x33,0x44. Require RAM writes at 0x3FE,0x3FF,0x000,0x001. Read-back at 0x3FE len=3 returns the same sequence.
- Back-pressure: read len=2 at 0x000 with rdata_ready held low 5 cycles per beat. Require rdata stable while valid, no address advance, 3 beats total, done after the third handshake.
- Strobe timing: during any write burst, check every cycle that ram_addr/ram_wdata are unchanged on the cycles before, during and after ram_wr=1, and that ram_wr high lasts exactly 1 cycle.
- Verify (macro defined): force ram_rdata=0x00 during a write of 0x5A at 0x020. Require verify_err=1 and verify_addr=0x020. Next command accept clears both. Without the macro, both stay 0.

Source files
------------

// File: rtl/ram_burst_master.sv
// ram_burst_master: burst initiator for a single-port RAM with asynchronous
// read and level-sensitive write. Write beats are framed as setup / strobe /
// hold so that address and data never move next to a write-enable pulse.
// Optional readback verification is enabled by defining
// RAM_BURST_MASTER_VERIFY_EN (adds a WCHK cycle per write beat).
module ram_burst_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              ram_cs,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              verify_err,
  output logic [ADDR_W-1:0] verify_addr
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WWAIT,
    S_WSETUP,
    S_WSTROBE,
    S_WHOLD,
`ifdef RAM_BURST_MASTER_VERIFY_EN
    S_WCHK,
`endif
    S_RADDR,
    S_RVALID,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rdata_valid_q, rdata_valid_d;
  logic                ram_cs_q, ram_cs_d;
  logic                ram_wr_q, ram_wr_d;
  logic                done_q, done_d;
`ifdef RAM_BURST_MASTER_VERIFY_EN
  logic                verify_err_q, verify_err_d;
  logic [ADDR_W-1:0]   verify_addr_q, verify_addr_d;
`endif

  logic last_beat;
  assign last_beat = (count_q == len_q);

  // Next-state, datapath updates, and the registered strobe values for the next cycle
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    count_d       = count_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = rdata_valid_q;
`ifdef RAM_BURST_MASTER_VERIFY_EN
    verify_err_d  = verify_err_q;
    verify_addr_d = verify_addr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          count_d = '0;
`ifdef RAM_BURST_MASTER_VERIFY_EN
          verify_err_d  = 1'b0;
          verify_addr_d = '0;
`endif
          state_d = cmd_wr ? S_WWAIT : S_RADDR;
        end
      end
      S_WWAIT: begin
        if (wdata_valid) begin
          wdata_d = wdata;
          state_d = S_WSETUP;
        end
      end
      S_WSETUP:  state_d = S_WSTROBE;
      S_WSTROBE: state_d = S_WHOLD;
      S_WHOLD: begin
`ifdef RAM_BURST_MASTER_VERIFY_EN
        state_d = S_WCHK;
`else
        if (last_beat) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          count_d = count_q + LEN_W'(1);
          state_d = S_WWAIT;
        end
`endif
      end
`ifdef RAM_BURST_MASTER_VERIFY_EN
      S_WCHK: begin
        // Only the first mismatch since the last command is recorded
        if ((ram_rdata != wdata_q) && !verify_err_q) begin
          verify_err_d  = 1'b1;
          verify_addr_d = addr_q;
        end
        if (last_beat) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          count_d = count_q + LEN_W'(1);
          state_d = S_WWAIT;
        end
      end
`endif
      S_RADDR: begin
        rdata_d       = ram_rdata;
        rdata_valid_d = 1'b1;
        state_d       = S_RVALID;
      end
      S_RVALID: begin
        if (rdata_ready) begin
          rdata_valid_d = 1'b0;
          if (last_beat) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            count_d = count_q + LEN_W'(1);
            state_d = S_RADDR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // RAM strobes and done are registered copies decoded from the next state
    ram_cs_d = (state_d == S_WSETUP) || (state_d == S_WSTROBE) ||
               (state_d == S_WHOLD)  || (state_d == S_RADDR)
`ifdef RAM_BURST_MASTER_VERIFY_EN
               || (state_d == S_WCHK)
`endif
               ;
    ram_wr_d = (state_d == S_WSTROBE);
    done_d   = (state_d == S_DONE);
  end

  // State and datapath registers; reset abandons any burst and drops ram_wr at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      count_q       <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      ram_cs_q      <= 1'b0;
      ram_wr_q      <= 1'b0;
      done_q        <= 1'b0;
`ifdef RAM_BURST_MASTER_VERIFY_EN
      verify_err_q  <= 1'b0;
      verify_addr_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      count_q       <= count_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      ram_cs_q      <= ram_cs_d;
      ram_wr_q      <= ram_wr_d;
      done_q        <= done_d;
`ifdef RAM_BURST_MASTER_VERIFY_EN
      verify_err_q  <= verify_err_d;
      verify_addr_q <= verify_addr_d;
`endif
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign wdata_ready = (state_q == S_WWAIT);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata       = rdata_q;
  assign ram_cs      = ram_cs_q;
  assign ram_wr      = ram_wr_q;
  assign ram_addr    = addr_q;
  assign ram_wdata   = wdata_q;
`ifdef RAM_BURST_MASTER_VERIFY_EN
  assign verify_err  = verify_err_q;
  assign verify_addr = verify_addr_q;
`else
  assign verify_err  = 1'b0;
  assign verify_addr = '0;
`endif

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: RAM model, write/read scoreboards, strobe monitor.
module tb_ram_burst_master;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          wdata_valid = 1'b0, wdata_ready;
  logic [DW-1:0] wdata = '0;
  logic          rdata_valid, rdata_ready = 1'b0;
  logic [DW-1:0] rdata;
  logic          busy, done, ram_cs, ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          verify_err;
  logic [AW-1:0] verify_addr;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          force_zero = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;

  logic [AW+DW-1:0] wr_exp[$];
  logic [DW-1:0]    rd_exp[$];

  always #5 clk = ~clk;

  ram_burst_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .busy(busy), .done(done),
    .ram_cs(ram_cs), .ram_wr(ram_wr), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .verify_err(verify_err), .verify_addr(verify_addr)
  );

  // RAM model: asynchronous read, write on clock edge while cs&wr
  assign ram_rdata = force_zero ? '0 : mem[ram_addr];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i) ^ 8'hC3;
  end
  always @(posedge clk) begin
    if (ram_cs && ram_wr) mem[ram_addr] <= ram_wdata;
  end

  // Monitor: write scoreboard, strobe framing, done counting
  initial begin : monitor
    logic          prev_wr, prev_valid;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wdata;
    logic [AW+DW-1:0] e;
    prev_wr = 1'b0; prev_valid = 1'b0; prev_addr = '0; prev_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_wr = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (ram_wr) begin
          total_cnt++;
          if (wr_exp.size() == 0) begin
            $display("FAIL unexpected_write addr=%h data=%h expected none", ram_addr, ram_wdata);
          end else begin
            e = wr_exp.pop_front();
            if ({ram_addr, ram_wdata} !== e)
              $display("FAIL write_beat got addr=%h data=%h expected addr=%h data=%h",
                       ram_addr, ram_wdata, e[AW+DW-1:DW], e[DW-1:0]);
            else pass_cnt++;
          end
          total_cnt++;
          if (!ram_cs || prev_wr || !prev_valid || ram_addr !== prev_addr || ram_wdata !== prev_wdata)
            $display("FAIL strobe_pre cs=%b prev_wr=%b addr=%h/%h data=%h/%h expected cs=1 prev_wr=0 stable",
                     ram_cs, prev_wr, ram_addr, prev_addr, ram_wdata, prev_wdata);
          else pass_cnt++;
          $display("write addr=%h data=%h", ram_addr, ram_wdata);
        end
        if (prev_wr) begin
          total_cnt++;
          if (ram_wr || !ram_cs || ram_addr !== prev_addr || ram_wdata !== prev_wdata)
            $display("FAIL strobe_post wr=%b cs=%b addr=%h/%h data=%h/%h expected wr=0 cs=1 stable",
                     ram_wr, ram_cs, ram_addr, prev_addr, ram_wdata, prev_wdata);
          else pass_cnt++;
        end
        if (done) done_cnt++;
        prev_wr = ram_wr;
        prev_addr = ram_addr;
        prev_wdata = ram_wdata;
        prev_valid = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired simulation time limit");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    int n;
    cmd_wr = wr; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
    total_cnt++;
    if (!cmd_ready) $display("FAIL cmd_accept_timeout cmd_ready=%b expected 1", cmd_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic write_beats(input logic [AW-1:0] a, input logic [DW-1:0] d[$]);
    int n;
    foreach (d[i]) begin
      wdata = d[i]; wdata_valid = 1'b1;
      wr_exp.push_back({AW'(a + AW'(i)), d[i]});
      n = 0;
      while (!wdata_ready && n < 100) begin @(posedge clk); #1; n++; end
      total_cnt++;
      if (!wdata_ready) $display("FAIL wdata_timeout wdata_ready=%b expected 1", wdata_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      wdata_valid = 1'b0;
    end
  endtask

  task automatic read_beats(input int beats, input int stall);
    int n;
    logic [DW-1:0] r, e;
    logic [AW-1:0] a;
    for (int b = 0; b < beats; b++) begin
      n = 0;
      while (!rdata_valid && n < 100) begin @(posedge clk); #1; n++; end
      total_cnt++;
      if (!rdata_valid) $display("FAIL rdata_timeout rdata_valid=%b expected 1", rdata_valid);
      else pass_cnt++;
      r = rdata; a = ram_addr;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        total_cnt++;
        if (rdata !== r || rdata_valid !== 1'b1 || ram_addr !== a)
          $display("FAIL rdata_hold rdata=%h valid=%b addr=%h expected rdata=%h valid=1 addr=%h",
                   rdata, rdata_valid, ram_addr, r, a);
        else pass_cnt++;
      end
      e = (rd_exp.size() != 0) ? rd_exp.pop_front() : 'x;
      total_cnt++;
      if (r !== e) $display("FAIL read_beat rdata=%h expected %h", r, e);
      else pass_cnt++;
      $display("read addr=%h data=%h", a, r);
      rdata_ready = 1'b1;
      @(posedge clk); #1;
      rdata_ready = 1'b0;
    end
  endtask

  task automatic finish_burst(input int d0);
    int n;
    n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    total_cnt++;
    if (busy || done_cnt - d0 != 1 || wr_exp.size() != 0 || rd_exp.size() != 0)
      $display("FAIL burst_end busy=%b done_pulses=%0d pending_wr=%0d pending_rd=%0d expected 0/1/0/0",
               busy, done_cnt - d0, wr_exp.size(), rd_exp.size());
    else pass_cnt++;
  endtask

  task automatic test_reset;
    int n, act;
    #1;
    total_cnt++;
    if ({cmd_ready, busy, done, ram_cs, ram_wr, rdata_valid, wdata_ready, verify_err} !== 8'b1000_0000)
      $display("FAIL reset_state outputs=%b expected 10000000",
               {cmd_ready, busy, done, ram_cs, ram_wr, rdata_valid, wdata_ready, verify_err});
    else pass_cnt++;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    // Start a write at 0x010 and reset it during the strobe
    cmd_wr = 1'b1; cmd_addr = 10'h010; cmd_len = '0; cmd_valid = 1'b1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    wdata = 8'h77; wdata_valid = 1'b1;
    @(posedge clk); #1; wdata_valid = 1'b0;
    n = 0;
    while (!ram_wr && n < 20) begin @(posedge clk); #1; n++; end
    total_cnt++;
    if (!ram_wr) $display("FAIL reset_reach_strobe ram_wr=%b expected 1", ram_wr);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (ram_wr !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ram_cs !== 1'b0)
      $display("FAIL reset_midwrite wr=%b ready=%b busy=%b done=%b cs=%b expected 0 1 0 0 0",
               ram_wr, cmd_ready, busy, done, ram_cs);
    else pass_cnt++;
    $display("reset asserted during strobe at addr 010");
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ram_cs || ram_wr || done || busy) act++;
    end
    total_cnt++;
    if (act != 0) $display("FAIL reset_quiet active_cycles=%0d expected 0", act);
    else pass_cnt++;
  endtask

  task automatic test_single;
    int d0;
    logic [DW-1:0] d[$];
    d = '{8'hA5};
    d0 = done_cnt;
    send_cmd(1'b1, 10'h005, 10'd0);
    write_beats(10'h005, d);
    finish_burst(d0);
    d0 = done_cnt;
    rd_exp.push_back(8'hA5);
    send_cmd(1'b0, 10'h005, 10'd0);
    read_beats(1, 0);
    finish_burst(d0);
  endtask

  task automatic test_wrap;
    int d0;
    logic [DW-1:0] d[$];
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    d0 = done_cnt;
    send_cmd(1'b1, 10'h3FE, 10'd3);
    write_beats(10'h3FE, d);
    finish_burst(d0);
    d0 = done_cnt;
    foreach (d[i]) rd_exp.push_back(d[i]);
    send_cmd(1'b0, 10'h3FE, 10'd3);
    read_beats(4, 0);
    finish_burst(d0);
  endtask

  task automatic test_backpressure;
    int d0;
    d0 = done_cnt;
    rd_exp.push_back(8'h33);
    rd_exp.push_back(8'h44);
    rd_exp.push_back(8'hC1);   // untouched location 0x002 keeps its preset pattern
    send_cmd(1'b0, 10'h000, 10'd2);
    read_beats(3, 5);
    total_cnt++;
    if (rdata_valid !== 1'b0) $display("FAIL bp_no_extra_beat rdata_valid=%b expected 0", rdata_valid);
    else pass_cnt++;
    finish_burst(d0);
  endtask

  task automatic test_verify;
    int d0;
    logic [DW-1:0] d[$];
    d = '{8'h5A};
    force_zero = 1'b1;
    d0 = done_cnt;
    send_cmd(1'b1, 10'h020, 10'd0);
    write_beats(10'h020, d);
    finish_burst(d0);
    force_zero = 1'b0;
    total_cnt++;
`ifdef RAM_BURST_MASTER_VERIFY_EN
    if (verify_err !== 1'b1 || verify_addr !== 10'h020)
      $display("FAIL verify_flag err=%b addr=%h expected 1 020", verify_err, verify_addr);
    else pass_cnt++;
`else
    if (verify_err !== 1'b0 || verify_addr !== 10'h000)
      $display("FAIL verify_flag err=%b addr=%h expected 0 000", verify_err, verify_addr);
    else pass_cnt++;
`endif
    d0 = done_cnt;
    rd_exp.push_back(8'h5A);
    send_cmd(1'b0, 10'h020, 10'd0);
    total_cnt++;
    if (verify_err !== 1'b0 || verify_addr !== 10'h000)
      $display("FAIL verify_clear err=%b addr=%h expected 0 000", verify_err, verify_addr);
    else pass_cnt++;
    read_beats(1, 0);
    finish_burst(d0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_verify();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
